// File: rtl/tri_bus_reader_pkg.sv
// Shared definitions for the tri-state bus receiver: FSM encodings and default widths.
// Default bus width matches the tri-state buffer register that drives the bus.
`default_nettype none

package tri_bus_reader_pkg;

   localparam int BUS_WIDTH_DEFAULT  = 8;
   localparam int FIFO_DEPTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ACK      = 2'd1,
      S_WAIT_REL = 2'd2
   } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/bus_rx_fifo.sv
// First-word-fall-through word FIFO for the bus receiver.
// Holds memory, pointers, occupancy and FULL/EMPTY flags.
`default_nettype none

module bus_rx_fifo #(
   parameter int reg_size = 8,
   parameter int DEPTH    = 4
) (
   input  logic                     clk_i,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  logic [reg_size-1:0]      wdata_i,
   input  logic                     pop_i,
   output logic [reg_size-1:0]      rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [reg_size-1:0] mem_q [DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q,  count_d;
   logic                do_push, do_pop;

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i  & ~empty_o;

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/tri_bus_reader.sv
// Receiving end of the shared tri-state register bus: 4-phase ACK handshake feeding a FIFO.
// Optional even-parity checking on the bus is enabled by defining BUS_PARITY_EN.
`default_nettype none

module tri_bus_reader
   import tri_bus_reader_pkg::*;
#(
   parameter int reg_size = BUS_WIDTH_DEFAULT,
   parameter int DEPTH    = FIFO_DEPTH_DEFAULT
) (
   input  logic                     CLOCK,
   input  logic                     CLEAR,
   input  logic [reg_size-1:0]      BUS,
   input  logic                     BUS_EN,
`ifdef BUS_PARITY_EN
   input  logic                     BUS_PAR,
   output logic                     PAR_ERR,
`endif
   output logic                     ACK,
   output logic [reg_size-1:0]      DOUT,
   output logic                     VALID,
   input  logic                     READ,
   output logic                     FULL,
   output logic                     EMPTY,
   output logic [$clog2(DEPTH):0]   COUNT
);

   rx_state_t state_q, state_d;
   logic      capture;
   logic      push;

   // FULL is the pre-edge value, so a pop on the same edge does not unblock a stalled transfer.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (BUS_EN && !FULL) begin
               capture = 1'b1;
               state_d = S_ACK;
            end
         end
         S_ACK:      state_d = S_WAIT_REL;
         S_WAIT_REL: if (!BUS_EN) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (CLEAR) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   assign ACK = (state_q == S_ACK);

`ifdef BUS_PARITY_EN
   logic par_bad;
   logic par_err_q, par_err_d;

   // A bad word is dropped but still acknowledged so the source frees the bus.
   assign par_bad   = ^{BUS, BUS_PAR};
   assign push      = capture & ~par_bad;
   assign par_err_d = par_err_q | (capture & par_bad);

   always_ff @(posedge CLOCK) begin
      if (CLEAR) par_err_q <= 1'b0;
      else       par_err_q <= par_err_d;
   end

   assign PAR_ERR = par_err_q;
`else
   assign push = capture;
`endif

   bus_rx_fifo #(
      .reg_size (reg_size),
      .DEPTH    (DEPTH)
   ) u_fifo (
      .clk_i    (CLOCK),
      .clear_i  (CLEAR),
      .push_i   (push),
      .wdata_i  (BUS),
      .pop_i    (READ),
      .rdata_o  (DOUT),
      .full_o   (FULL),
      .empty_o  (EMPTY),
      .count_o  (COUNT)
   );

   assign VALID = ~EMPTY;

endmodule

`default_nettype wire
